// File: rtl/reg_file_mp.sv
// Multi-read-port register file for the multi-cycle MIPS datapath: one decoded
// write port, post-reset clearing sweep, optional write-first bypass and a pending scoreboard.
module reg_file_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_READ    = 2,
    parameter int LINK_REG    = 31,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    input  logic                         wr_en,
    input  logic [1:0]                   wr_dst_sel,
    input  logic                         wr_src_sel,
    input  logic [ADDR_W-1:0]            rt_addr,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W-1:0]            pc_in,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr_bus,
    output logic [NUM_READ*DATA_W-1:0]   rd_data_bus,
    input  logic                         pend_set,
    input  logic [ADDR_W-1:0]            pend_addr,
    output logic [NUM_READ-1:0]          pend_bus,
    output logic                         wr_drop
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam bit                ZERO_EN   = (ZERO_REG_EN != 0);
    localparam bit                BYP_EN    = (BYPASS_EN != 0);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_nxt;

    logic              run;
    logic [ADDR_W-1:0] wdest;
    logic [DATA_W-1:0] wval;
    logic              do_write;

    assign run   = (state_q == ST_RUN);
    assign ready = run;

    // Destination decode and write qualification; the link value wraps modulo 2**DATA_W.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wdest = LINK_ADDR;
        case (wr_dst_sel)
            2'b01:   wdest = rt_addr;
            2'b10:   wdest = rd_addr;
            default: wdest = LINK_ADDR;
        endcase
        wval     = wr_src_sel ? wr_data : pc_in + DATA_W'(4);
        do_write = run && wr_en && (wr_dst_sel != 2'b11) && !(ZERO_EN && (wdest == '0));
    end

    assign wr_drop = wr_en && !do_write;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                state_q <= ST_RUN;
            end
        end
    end

    // NOTE: the array has no reset term; the INIT sweep clears one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                regs[cnt_q] <= '0;
            end else if (do_write) begin
                regs[wdest] <= wval;
            end
        end
    end

    // Clear is applied before set so a same-cycle reissue of a load keeps the bit pending.
    always_comb begin
        pend_nxt = pend_q;
        if (do_write) begin
            pend_nxt[wdest] = 1'b0;
        end
        if (run && pend_set && !(ZERO_EN && (pend_addr == '0))) begin
            pend_nxt[pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    logic [ADDR_W-1:0] port_addr;
    logic              byp_hit;

    always_comb begin
        rd_data_bus = '0;
        pend_bus    = '0;
        port_addr   = '0;
        byp_hit     = 1'b0;
        for (int k = 0; k < NUM_READ; k++) begin
            port_addr = rd_addr_bus[k*ADDR_W +: ADDR_W];
            byp_hit   = BYP_EN && do_write && (wdest == port_addr);
            if (run) begin
                if (ZERO_EN && (port_addr == '0)) begin
                    rd_data_bus[k*DATA_W +: DATA_W] = '0;
                end else if (byp_hit) begin
                    rd_data_bus[k*DATA_W +: DATA_W] = wval;
                end else begin
                    rd_data_bus[k*DATA_W +: DATA_W] = regs[port_addr];
                end
                pend_bus[k] = pend_q[port_addr] && !byp_hit;
            end
        end
    end

endmodule
